issue_reg: RTL and testbench

- ID→EX issue stage and pipeline register.
- Takes the decoded instruction plus two forwarded operands, each with an operand-valid flag from a forwarding checker. Issues the instruction into EX only when both operands are valid and EX can accept.
- Otherwise it holds decode and presents a bubble downstream.
- Keeps a stall-cause state machine and saturating stall counters for performance debug.

---
 rtl/issue_reg_pkg.sv | 13 +
 rtl/issue_reg_sat_counter.sv | 20 ++
 rtl/issue_reg.sv | 116 +++++++++++
 tb/tb_issue_reg.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_reg_pkg.sv
// Shared types for the ID->EX issue stage: stall-cause encodings and register-address width.
// Constants only; no latency or backpressure of its own.
package issue_reg_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        ISSUE_RUN        = 2'd0,
        ISSUE_STALL_DATA = 2'd1,
        ISSUE_STALL_EX   = 2'd2
    } issue_state_e;

endpackage

// File: rtl/issue_reg_sat_counter.sv
// Saturating up-counter with enable and synchronous reset; it sticks at all-ones.
// Latency: count is visible 1 cycle after the enable. It has no backpressure.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (en && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/issue_reg.sv
// ID->EX issue register: an instruction issues when both operands are final and the EX slot frees.
// Latency: 1 cycle. Backpressure: id_ready drops on operand stall, EX hold or flush; it never depends on next ex_valid.
module issue_reg
    import issue_reg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int UOP_W  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  id_valid,
    output logic                  id_ready,
    input  logic [DATA_W-1:0]     id_pc,
    input  logic [UOP_W-1:0]      id_uop,
    input  logic [REG_ADDR_W-1:0] id_dest_addr,
    input  logic                  id_dest_wen,
    input  logic [DATA_W-1:0]     ope_a,
    input  logic                  ope_a_valid,
    input  logic [DATA_W-1:0]     ope_b,
    input  logic                  ope_b_valid,
    output logic                  ex_valid,
    input  logic                  ex_ready,
    output logic [DATA_W-1:0]     ex_pc,
    output logic [UOP_W-1:0]      ex_uop,
    output logic [DATA_W-1:0]     ex_ope_a,
    output logic [DATA_W-1:0]     ex_ope_b,
    output logic [REG_ADDR_W-1:0] ex_dest_addr,
    output logic                  ex_dest_wen,
    output logic [CNT_W-1:0]      stall_data_cnt,
    output logic [CNT_W-1:0]      stall_ex_cnt
);

    logic         ops_ok;
    logic         slot_free;
    logic         fire;
    issue_state_e state_q;
    issue_state_e state_d;
    issue_state_e cause;

    assign ops_ok    = ope_a_valid & ope_b_valid;
    assign slot_free = !ex_valid | ex_ready;
    assign id_ready  = ops_ok & slot_free & !flush;
    assign fire      = id_valid & id_ready;

    // Operands are captured only on the fire edge, so forwarding updates during a stall are picked up.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_uop       <= '0;
            ex_ope_a     <= '0;
            ex_ope_b     <= '0;
            ex_dest_addr <= '0;
            ex_dest_wen  <= 1'b0;
        end else if (flush) begin
            ex_valid    <= 1'b0;
            ex_dest_wen <= 1'b0;
        end else if (fire) begin
            ex_valid     <= 1'b1;
            ex_pc        <= id_pc;
            ex_uop       <= id_uop;
            ex_ope_a     <= ope_a;
            ex_ope_b     <= ope_b;
            ex_dest_addr <= id_dest_addr;
            ex_dest_wen  <= id_dest_wen;
        end else if (slot_free) begin
            ex_valid    <= 1'b0;
            ex_dest_wen <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ISSUE_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Missing operands outrank EX back-pressure as the reported cause.
    always_comb begin
        cause = ISSUE_RUN;
        if (id_valid && !flush) begin
            if (!ops_ok) begin
                cause = ISSUE_STALL_DATA;
            end else if (!slot_free) begin
                cause = ISSUE_STALL_EX;
            end
        end
    end

    always_comb begin
        state_d = ISSUE_RUN;
        case (state_q)
            ISSUE_RUN, ISSUE_STALL_DATA, ISSUE_STALL_EX: state_d = cause;
            default:                                     state_d = ISSUE_RUN;
        endcase
    end

    sat_counter #(.W(CNT_W)) u_stall_data_cnt (
        .clk (clk),
        .rst (rst),
        .en  (state_d == ISSUE_STALL_DATA),
        .cnt (stall_data_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_ex_cnt (
        .clk (clk),
        .rst (rst),
        .en  (state_d == ISSUE_STALL_EX),
        .cnt (stall_ex_cnt)
    );

endmodule

// File: tb/tb_issue_reg.sv
// Bench for issue_reg: directed scenarios plus random traffic against a slot-occupancy model.
// A default-width instance and a 4-bit-counter instance share the same stimulus.
module tb_issue_reg;

    logic        clk = 1'b0;
    logic        rst, flush, id_valid, id_dest_wen, ope_a_valid, ope_b_valid, ex_ready;
    logic [31:0] id_pc, ope_a, ope_b;
    logic [7:0]  id_uop;
    logic [4:0]  id_dest_addr;

    logic        id_ready, ex_valid, ex_dest_wen;
    logic [31:0] ex_pc, ex_ope_a, ex_ope_b;
    logic [7:0]  ex_uop;
    logic [4:0]  ex_dest_addr;
    logic [15:0] stall_data_cnt, stall_ex_cnt;

    logic        s_id_ready, s_ex_valid, s_ex_dest_wen;
    logic [31:0] s_ex_pc, s_ex_ope_a, s_ex_ope_b;
    logic [7:0]  s_ex_uop;
    logic [4:0]  s_ex_dest_addr;
    logic [3:0]  s_stall_data_cnt, s_stall_ex_cnt;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    issue_reg dut (
        .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_uop(id_uop), .id_dest_addr(id_dest_addr), .id_dest_wen(id_dest_wen),
        .ope_a(ope_a), .ope_a_valid(ope_a_valid), .ope_b(ope_b), .ope_b_valid(ope_b_valid),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_uop(ex_uop),
        .ex_ope_a(ex_ope_a), .ex_ope_b(ex_ope_b), .ex_dest_addr(ex_dest_addr),
        .ex_dest_wen(ex_dest_wen), .stall_data_cnt(stall_data_cnt), .stall_ex_cnt(stall_ex_cnt)
    );

    issue_reg #(.CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ready(s_id_ready),
        .id_pc(id_pc), .id_uop(id_uop), .id_dest_addr(id_dest_addr), .id_dest_wen(id_dest_wen),
        .ope_a(ope_a), .ope_a_valid(ope_a_valid), .ope_b(ope_b), .ope_b_valid(ope_b_valid),
        .ex_valid(s_ex_valid), .ex_ready(ex_ready), .ex_pc(s_ex_pc), .ex_uop(s_ex_uop),
        .ex_ope_a(s_ex_ope_a), .ex_ope_b(s_ex_ope_b), .ex_dest_addr(s_ex_dest_addr),
        .ex_dest_wen(s_ex_dest_wen), .stall_data_cnt(s_stall_data_cnt), .stall_ex_cnt(s_stall_ex_cnt)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the EX slot is either empty or holds one instruction; stall cycles are tallied unbounded.
    bit          armed = 1'b0;
    bit          m_occ;
    logic [31:0] m_pc, m_a, m_b;
    logic [7:0]  m_uop;
    logic [4:0]  m_dest;
    bit          m_wen;
    int          m_dc, m_ec;

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic cmp(input string tag, input logic rdy, input logic v, input logic [31:0] pc,
                       input logic [7:0] uop, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] dest, input logic wen, input int dc, input int ec,
                       input int maxc);
        bit exp_rdy;
        exp_rdy = ope_a_valid && ope_b_valid && (!m_occ || ex_ready) && !flush;
        chk({tag, "id_ready"}, rdy, exp_rdy);
        chk({tag, "ex_valid"}, v, m_occ);
        chk({tag, "ex_dest_wen"}, wen, m_occ ? m_wen : 1'b0);
        chk({tag, "stall_data_cnt"}, dc, sat(m_dc, maxc));
        chk({tag, "stall_ex_cnt"}, ec, sat(m_ec, maxc));
        if (m_occ) begin
            chk({tag, "ex_pc"}, pc, m_pc);
            chk({tag, "ex_uop"}, uop, m_uop);
            chk({tag, "ex_ope_a"}, a, m_a);
            chk({tag, "ex_ope_b"}, b, m_b);
            chk({tag, "ex_dest_addr"}, dest, m_dest);
        end
    endtask

    // Inputs change at posedge+2, so at the negedge they are the values the next posedge samples.
    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                cmp("w16.", id_ready, ex_valid, ex_pc, ex_uop, ex_ope_a, ex_ope_b, ex_dest_addr,
                    ex_dest_wen, int'(stall_data_cnt), int'(stall_ex_cnt), 65535);
                cmp("w4.", s_id_ready, s_ex_valid, s_ex_pc, s_ex_uop, s_ex_ope_a, s_ex_ope_b,
                    s_ex_dest_addr, s_ex_dest_wen, int'(s_stall_data_cnt), int'(s_stall_ex_cnt), 15);
            end
            if (rst) begin
                armed = 1'b1;
                m_occ = 1'b0;
                m_wen = 1'b0;
                m_dc  = 0;
                m_ec  = 0;
            end else if (armed) begin
                bit ops, issue;
                ops   = ope_a_valid && ope_b_valid;
                issue = id_valid && ops && (!m_occ || ex_ready) && !flush;
                if (id_valid && !flush && !issue) begin
                    if (!ops) m_dc++;
                    else      m_ec++;
                end
                if (issue) begin
                    m_occ  = 1'b1;
                    m_pc   = id_pc;
                    m_uop  = id_uop;
                    m_a    = ope_a;
                    m_b    = ope_b;
                    m_dest = id_dest_addr;
                    m_wen  = id_dest_wen;
                end else if (flush || ex_ready) begin
                    m_occ = 1'b0;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_instr(input logic [31:0] pc, input logic [4:0] dest, input logic wen);
        id_valid     = 1'b1;
        id_pc        = pc;
        id_uop       = pc[9:2];
        id_dest_addr = dest;
        id_dest_wen  = wen;
        ope_a        = pc ^ 32'hA5A5_0000;
        ope_b        = pc ^ 32'h0000_5A5A;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; id_valid = 1'b0; id_dest_wen = 1'b0;
        ope_a_valid = 1'b0; ope_b_valid = 1'b0; ex_ready = 1'b0;
        id_pc = '0; ope_a = '0; ope_b = '0; id_uop = '0; id_dest_addr = '0;
        cyc(); cyc();
        rst = 1'b0;

        // Reset state
        ope_a_valid = 1'b1; ope_b_valid = 1'b1; ex_ready = 1'b1;
        #1;
        chk("rst.id_ready", id_ready, 1'b1);
        chk("rst.ex_valid", ex_valid, 1'b0);
        chk("rst.ex_dest_wen", ex_dest_wen, 1'b0);
        chk("rst.ex_pc", ex_pc, 32'h0);
        chk("rst.data_cnt", stall_data_cnt, 16'd0);
        chk("rst.ex_cnt", stall_ex_cnt, 16'd0);

        // Back-to-back issue
        for (int i = 0; i < 3; i++) begin
            set_instr(32'h1c00_0000 + 32'(4 * i), 5'(i + 1), 1'b1);
            #1;
            chk("b2b.id_ready", id_ready, 1'b1);
            cyc();
            chk("b2b.ex_pc", ex_pc, 32'h1c00_0000 + 32'(4 * i));
            chk("b2b.ex_valid", ex_valid, 1'b1);
        end
        chk("b2b.data_cnt", stall_data_cnt, 16'd0);
        chk("b2b.ex_cnt", stall_ex_cnt, 16'd0);

        // Operand-A stall, operand changes while waiting
        set_instr(32'h1c00_000c, 5'd7, 1'b1);
        ope_a = 32'h11; ope_a_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("data.id_ready", id_ready, 1'b0);
            cyc();
            chk("data.bubble", ex_valid, 1'b0);
        end
        ope_a = 32'h55; ope_a_valid = 1'b1;
        cyc();
        chk("data.ex_valid", ex_valid, 1'b1);
        chk("data.ex_ope_a", ex_ope_a, 32'h55);
        chk("data.cnt", stall_data_cnt, 16'd3);

        // EX back-pressure for 4 cycles
        ex_ready = 1'b0;
        set_instr(32'h1c00_0010, 5'd9, 1'b1);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("exbp.id_ready", id_ready, 1'b0);
            cyc();
            chk("exbp.hold_pc", ex_pc, 32'h1c00_000c);
            chk("exbp.hold_a", ex_ope_a, 32'h55);
        end
        chk("exbp.cnt", stall_ex_cnt, 16'd4);
        ex_ready = 1'b1;
        cyc();
        chk("exbp.load_pc", ex_pc, 32'h1c00_0010);
        chk("exbp.cnt_after", stall_ex_cnt, 16'd4);

        // Flush against a would-be fire
        set_instr(32'h1c00_0014, 5'd3, 1'b1);
        flush = 1'b1;
        #1;
        chk("flush.id_ready", id_ready, 1'b0);
        cyc();
        chk("flush.ex_valid", ex_valid, 1'b0);
        chk("flush.ex_dest_wen", ex_dest_wen, 1'b0);
        flush = 1'b0;
        cyc();
        chk("flush.reissue_valid", ex_valid, 1'b1);
        chk("flush.reissue_pc", ex_pc, 32'h1c00_0014);
        chk("flush.cnt_kept", stall_ex_cnt, 16'd4);

        // Counter saturation on the 4-bit instance (it already holds 3)
        set_instr(32'h1c00_0018, 5'd4, 1'b0);
        ope_b_valid = 1'b0;
        repeat (20) cyc();
        chk("sat.w4_cnt", s_stall_data_cnt, 4'd15);
        chk("sat.w16_cnt", stall_data_cnt, 16'd23);
        cyc();
        chk("sat.w4_hold", s_stall_data_cnt, 4'd15);
        ope_b_valid = 1'b1;
        id_valid = 1'b0;
        cyc();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            rst         = ($urandom_range(0, 199) == 0);
            flush       = ($urandom_range(0, 15) == 0);
            id_valid    = ($urandom_range(0, 3) != 0);
            ope_a_valid = ($urandom_range(0, 4) != 0);
            ope_b_valid = ($urandom_range(0, 4) != 0);
            ex_ready    = ($urandom_range(0, 2) != 0);
            id_pc        = $urandom;
            id_uop       = 8'($urandom);
            id_dest_addr = 5'($urandom);
            id_dest_wen  = 1'($urandom);
            ope_a        = $urandom;
            ope_b        = $urandom;
            cyc();
        end
        rst = 1'b0; flush = 1'b0; id_valid = 1'b0;
        cyc(); cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
